// File: rtl/huff_stream_decoder.sv
// Streaming Huffman decoder: CAM-style codebook, 2-word MSB-aligned bit buffer,
// one symbol per cycle into a registered valid/ready output stage.
module huff_stream_decoder #(
  parameter int WORD_W  = 32,
  parameter int SYM_W   = 5,
  parameter int MAX_LEN = 16,
  parameter int DEPTH   = 32,
  localparam int LEN_W  = $clog2(MAX_LEN+1),
  localparam int LB_W   = $clog2(WORD_W),
  localparam int CNT_W  = $clog2(DEPTH+1),
  localparam int CB_W   = LEN_W+SYM_W+MAX_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cb_wvalid,
  output logic              cb_wready,
  input  logic [CB_W-1:0]   cb_wdata,
  input  logic              cb_clear,
  output logic [CNT_W-1:0]  cb_count,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic [LB_W-1:0]   in_last_bits,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SYM_W-1:0]  out_sym,
  output logic              out_last,
  output logic              busy,
  output logic              err
);
  localparam int BUF_W  = 2*WORD_W;
  localparam int FILL_W = $clog2(BUF_W+1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_ERR} state_t;

  state_t st, st_nx;

  logic [DEPTH-1:0][LEN_W-1:0]   cb_len;
  logic [DEPTH-1:0][SYM_W-1:0]   cb_sym;
  logic [DEPTH-1:0][MAX_LEN-1:0] cb_code;
  logic [DEPTH-1:0]              hit;

  logic [BUF_W-1:0]  buf_q, buf_sh, buf_nx;
  logic [FILL_W-1:0] fill, fill_sh, fill_nx, app_n;
  logic [WORD_W-1:0] in_masked;
  logic [LEN_W-1:0]  m_len;
  logic [SYM_W-1:0]  m_sym;
  logic              hit_any, fire, take, miss, in_fire, cb_we, done;

  assign cb_we = cb_wvalid && cb_wready && !cb_clear;

  // codebook: append at cb_count, clear wins over a simultaneous write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cb_count <= '0;
      cb_len   <= '0;
      cb_sym   <= '0;
      cb_code  <= '0;
    end else if (st == S_IDLE && cb_clear) begin
      cb_count <= '0;
    end else if (cb_we) begin
      cb_count <= cb_count + 1'b1;
      for (int e = 0; e < DEPTH; e++)
        if (cb_count == CNT_W'(e))
          {cb_len[e], cb_sym[e], cb_code[e]} <= cb_wdata;
    end
  end

  // per-entry compare of the top len bits against the MSB-aligned code
  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    huff_cam_entry #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .FILL_W(FILL_W)) u_ent (
      .en   (CNT_W'(e) < cb_count),
      .len  (cb_len[e]),
      .code (cb_code[e]),
      .head (buf_q[BUF_W-1 -: MAX_LEN]),
      .fill (fill),
      .hit  (hit[e])
    );
  end

  // lowest-index match wins: scan downward so the last write is the lowest hit
  always_comb begin
    hit_any = 1'b0;
    m_len   = '0;
    m_sym   = '0;
    for (int e = DEPTH-1; e >= 0; e--)
      if (hit[e]) begin
        hit_any = 1'b1;
        m_len   = cb_len[e];
        m_sym   = cb_sym[e];
      end
  end

  assign fire    = (!out_valid || out_ready) &&
                   ((st == S_RUN && fill >= FILL_W'(MAX_LEN)) || (st == S_DRAIN && fill != '0));
  assign take    = fire && hit_any;
  assign miss    = fire && !hit_any;
  assign in_fire = in_valid && in_ready;
  assign done    = st == S_DRAIN && fill == '0 && out_valid && out_last && out_ready;

  // consume first, then append the new word behind the surviving bits;
  // bits below fill are kept zero so the append can simply OR in
  always_comb begin
    app_n     = (in_last && in_last_bits != '0) ? FILL_W'(in_last_bits) : FILL_W'(WORD_W);
    in_masked = in_data & ~({WORD_W{1'b1}} >> app_n);
    buf_sh    = take ? (buf_q << m_len) : buf_q;
    fill_sh   = take ? (fill - FILL_W'(m_len)) : fill;
    buf_nx    = buf_sh;
    fill_nx   = fill_sh;
    if (in_fire) begin
      buf_nx  = buf_sh | ({in_masked, {WORD_W{1'b0}}} >> fill_sh);
      fill_nx = fill_sh + app_n;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= S_IDLE;
    else      st <= st_nx;
  end

  // next-state: abort overrides everything; a decode miss beats end-of-stream
  always_comb begin
    st_nx = st;
    case (st)
      S_IDLE:  if (start) st_nx = (cb_count == '0) ? S_ERR : S_RUN;
      S_RUN:   if (miss) st_nx = S_ERR;
               else if (in_fire && in_last) st_nx = S_DRAIN;
      S_DRAIN: if (miss) st_nx = S_ERR;
               else if (done) st_nx = S_IDLE;
      default: st_nx = S_ERR;
    endcase
    if (abort) st_nx = S_IDLE;
  end

  // state-decoded handshakes and status
  always_comb begin
    cb_wready = (st == S_IDLE) && (cb_count < CNT_W'(DEPTH));
    in_ready  = (st == S_RUN) && (fill <= FILL_W'(BUF_W-WORD_W));
    busy      = (st != S_IDLE);
  end

  // bit buffer, output register and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q     <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      out_sym   <= '0;
      out_last  <= 1'b0;
      err       <= 1'b0;
    end else if (abort) begin
      buf_q     <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      buf_q <= buf_nx;
      fill  <= fill_nx;
      if (take) begin
        out_valid <= 1'b1;
        out_sym   <= m_sym;
        out_last  <= (st == S_DRAIN) && (fill_sh == '0);
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (st_nx == S_ERR) err <= 1'b1;
    end
  end
endmodule

// One codebook lane: nonzero, in-range length, enough buffered bits, prefix equal.
module huff_cam_entry #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int FILL_W  = 7
) (
  input  logic               en,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] code,
  input  logic [MAX_LEN-1:0] head,
  input  logic [FILL_W-1:0]  fill,
  output logic               hit
);
  logic [MAX_LEN-1:0] mask;
  assign mask = ~({MAX_LEN{1'b1}} >> len);
  assign hit  = en && len != '0 && len <= LEN_W'(MAX_LEN) && FILL_W'(len) <= fill &&
                (((head ^ code) & mask) == '0);
endmodule

// File: tb/tb_huff_stream_decoder.sv
// Self-checking bench: vector table of single-word streams plus hand-written
// backpressure, codebook-full and mid-stream-reset sequences; symbols are
// checked by a scoreboard queue filled when the stimulus is driven.
module tb_huff_stream_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cb_wvalid = 1'b0, cb_wready, cb_clear = 1'b0;
  logic [25:0] cb_wdata = '0;
  logic [5:0]  cb_count;
  logic        start = 1'b0, abort = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [31:0] in_data = '0;
  logic [4:0]  in_last_bits = '0;
  logic        out_valid, out_ready = 1'b1, out_last, busy, err;
  logic [4:0]  out_sym;

  huff_stream_decoder dut (
    .clk(clk), .rst(rst),
    .cb_wvalid(cb_wvalid), .cb_wready(cb_wready), .cb_wdata(cb_wdata),
    .cb_clear(cb_clear), .cb_count(cb_count),
    .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_last_bits(in_last_bits),
    .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
    .out_last(out_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] sym; logic last; } exp_t;
  typedef struct {
    logic [31:0]     data;
    logic [4:0]      lbits;
    int              n;
    logic [3:0][4:0] syms;
    logic            e;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[6];
  int   n_tests = 0, n_fail = 0;
  logic bp_mode = 1'b0, ready_lvl = 1'b1;
  logic held_v = 1'b0;
  logic [5:0] held;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // out_ready driver: toggles in backpressure mode, otherwise follows ready_lvl
  initial forever begin
    @(posedge clk); #1;
    if (bp_mode) out_ready = ~out_ready;
    else         out_ready = ready_lvl;
  end

  // scoreboard + stall-stability monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_out: got sym %0h last %0b expected none", out_sym, out_last);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("out_sym", 32'(out_sym), 32'(x.sym));
        chk("out_last", 32'(out_last), 32'(x.last));
      end
    end
    if (rst && held_v && out_valid) chk("stall_hold", 32'({out_sym, out_last}), 32'(held));
    held_v = rst && out_valid && !out_ready;
    held   = {out_sym, out_last};
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic cb_write(input logic [4:0] len, input logic [4:0] sym,
                          input logic [15:0] code, input logic exp_rdy);
    cb_wdata  = {len, sym, code};
    cb_wvalid = 1'b1;
    @(negedge clk);
    chk("cb_wready", 32'(cb_wready), 32'(exp_rdy));
    @(posedge clk); #1;
    cb_wvalid = 1'b0;
  endtask

  task automatic load_basic();
    cb_write(5'd1, 5'd3, 16'h0000, 1'b1);
    cb_write(5'd2, 5'd7, 16'h8000, 1'b1);
    cb_write(5'd2, 5'd1, 16'hC000, 1'b1);
    @(negedge clk);
    chk("cb_count_basic", 32'(cb_count), 32'd3);
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [4:0] lb);
    logic ok;
    ok = 1'b0;
    in_data = d; in_last = last; in_last_bits = lb; in_valid = 1'b1;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("in_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_end(input int budget);
    int c;
    c = 0;
    do begin @(negedge clk); c++; end while (busy && !err && c < budget);
  endtask

  task automatic run_vec(input int i);
    for (int k = 0; k < vecs[i].n; k++)
      exp_q.push_back({vecs[i].syms[k], (k == vecs[i].n-1) && !vecs[i].e});
    pulse_start();
    chk($sformatf("v%0d_busy_run", i), 32'(busy), 32'd1);
    send_word(vecs[i].data, 1'b1, vecs[i].lbits);
    wait_end(100);
    chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].e));
    chk($sformatf("v%0d_busy_end", i), 32'(busy), 32'(vecs[i].e));
    chk($sformatf("v%0d_pending", i), exp_q.size(), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    if (vecs[i].e) begin
      pulse_abort();
      @(negedge clk);
      chk($sformatf("v%0d_abort_err", i), 32'(err), 32'd0);
      chk($sformatf("v%0d_abort_busy", i), 32'(busy), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vecs[0] = '{32'hB0000000, 5'd5, 3, {5'd0, 5'd3, 5'd1, 5'd7}, 1'b0};
    vecs[1] = '{32'hB4000000, 5'd6, 3, {5'd0, 5'd3, 5'd1, 5'd7}, 1'b1};
    vecs[2] = '{32'h00000000, 5'd3, 3, {5'd0, 5'd3, 5'd3, 5'd3}, 1'b0};
    vecs[3] = '{32'hC0000000, 5'd2, 1, {5'd0, 5'd0, 5'd0, 5'd1}, 1'b0};
    vecs[4] = '{32'hF0000000, 5'd4, 2, {5'd0, 5'd0, 5'd1, 5'd1}, 1'b0};
    vecs[5] = '{32'h80000000, 5'd1, 0, {5'd0, 5'd0, 5'd0, 5'd0}, 1'b1};

    // reset values
    #12;
    chk("rst_cb_wready", 32'(cb_wready), 32'd1);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_cb_count",  32'(cb_count),  32'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    load_basic();
    for (int i = 0; i < 6; i++) run_vec(i);

    // backpressure: three all-zero words, 96 symbols of 3, last word full width
    for (int k = 0; k < 96; k++) exp_q.push_back({5'd3, k == 95});
    bp_mode = 1'b1;
    pulse_start();
    send_word(32'h0, 1'b0, 5'd0);
    send_word(32'h0, 1'b0, 5'd0);
    send_word(32'h0, 1'b1, 5'd0);
    wait_end(2000);
    chk("bp_busy", 32'(busy), 32'd0);
    chk("bp_err", 32'(err), 32'd0);
    chk("bp_pending", exp_q.size(), 32'd0);
    exp_q.delete();
    bp_mode = 1'b0; ready_lvl = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1;

    // codebook full, clear-with-write, start on empty codebook
    cb_clear = 1'b1; @(posedge clk); #1; cb_clear = 1'b0;
    for (int i = 0; i < 33; i++) cb_write(5'd1, 5'(i), 16'h0, i < 32);
    @(negedge clk);
    chk("full_count", 32'(cb_count), 32'd32);
    chk("full_wready", 32'(cb_wready), 32'd0);
    @(posedge clk); #1;
    cb_clear = 1'b1; cb_wvalid = 1'b1; cb_wdata = {5'd1, 5'd9, 16'h0};
    @(posedge clk); #1;
    cb_clear = 1'b0; cb_wvalid = 1'b0;
    @(negedge clk);
    chk("clear_count", 32'(cb_count), 32'd0);
    @(posedge clk); #1;
    pulse_start();
    @(negedge clk);
    chk("empty_start_err", 32'(err), 32'd1);
    chk("empty_start_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    pulse_abort();
    @(negedge clk);
    chk("empty_abort_err", 32'(err), 32'd0);
    @(posedge clk); #1;

    // reset mid-stream while the output is stalled with bits buffered
    load_basic();
    ready_lvl = 1'b0;
    @(posedge clk); #1;
    pulse_start();
    send_word(32'h0, 1'b0, 5'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_out_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_sym",   32'(out_sym),   32'd0);
    chk("mid_rst_out_last",  32'(out_last),  32'd0);
    chk("mid_rst_busy",      32'(busy),      32'd0);
    chk("mid_rst_in_ready",  32'(in_ready),  32'd0);
    chk("mid_rst_cb_wready", 32'(cb_wready), 32'd1);
    chk("mid_rst_cb_count",  32'(cb_count),  32'd0);
    exp_q.delete();
    ready_lvl = 1'b1;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    load_basic();
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
